// File: rtl/serial_subtractor.sv
// +-----------------------------------------------------------------------+
// | serial_subtractor: bit-serial LSB-first a - b with start/done (rev 1.0)|
// +-----------------------------------------------------------------------+
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             burrow,
  output logic             zero
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d_bit;
  logic             bout;
  logic             last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    d_bit      = sa[0] ^ sb[0] ^ bin;
    bout       = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
    res_next   = {d_bit, res[WIDTH-1:1]};
    last_step  = (cnt == LAST_STEP);
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result outputs only move on the completion edge; they hold through a following RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      burrow <= 1'b0;
      zero   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            res  <= '0;
            bin  <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_next;
          bin <= bout;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            diff   <= res_next;
            burrow <= bout;
            zero   <= (res_next == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial N-bit subtractor computing `diff = a - b` LSB-first, one full-subtractor step per clock, with a registered borrow chained between steps. It generalises the combinational half subtractor to arbitrary width with a start/done handshake. It serves the visitor-counter datapath wherever a multi-bit subtract or compare is needed without a wide combinational borrow chain.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range `WIDTH >= 2`.

Ports:
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `start`  input  1  request; sampled only while idle
- `a`  input  WIDTH  minuend; captured on the accepted `start`
- `b`  input  WIDTH  subtrahend; captured on the accepted `start`
- `busy`  output  1  high while a subtraction is in progress
- `done`  output  1  one-cycle pulse when results update
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH` of the last completed operation
- `burrow`  output  1  final borrow-out; 1 iff `a < b` (unsigned)
- `zero`  output  1  1 iff last `diff == 0`, meaning `a == b`

## Operation
- FSM states: IDLE and RUN.
- IDLE: if `start`=1 at a rising edge, do the following, then go to RUN:
  - load `a` and `b` into internal shift registers `sa` and `sb`;
  - clear the internal borrow flop `bin` to 0;
  - clear the step counter, which is `$clog2(WIDTH+1)` bits wide;
  - assert `busy`.
- RUN, each edge, one full-subtract step on the LSBs:
  - `d = sa[0] ^ sb[0] ^ bin`
  - `bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin)`
  - `d` shifts into the MSB of the internal result register, with right shift.
  - `sa` and `sb` shift right.
  - `bin <= bout`.
  - The counter increments.
- On step WIDTH, the final step:
  - `diff` takes the completed result;
  - `burrow` takes the final `bout`;
  - `zero` takes the result of comparing the completed result to 0;
  - `done` is set to 1;
  - `busy` is cleared to 0;
  - the FSM returns to IDLE.
- `diff`, `burrow` and `zero` change only on a completion edge and hold otherwise, including throughout a following RUN.
- `start` while `busy`=1 is ignored; the operands in flight are unaffected.
- `a` and `b` are don't-care except on the accepting edge.
- Arithmetic is unsigned modulo `2^WIDTH`; wrap-around is reported via `burrow`, never saturated.

## Timing
- Reset, asynchronous on `rst_n`=0:
  - FSM goes to IDLE;
  - `busy`=0, `done`=0;
  - `diff`=0, `burrow`=0, `zero`=1;
  - internal shift registers, `bin` and the counter are cleared.
- Release of `rst_n` is synchronous to `clk`; the first `start` is accepted on the first edge with `rst_n`=1.
- Latency: with `start` accepted at edge k, `busy`=1 from k up to edge k+WIDTH.
- At edge k+WIDTH the results update and `done`=1 for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
- Throughput: `start` may be high in the `done` cycle. The FSM is IDLE then, so the new operation is accepted at edge k+WIDTH+1. Back-to-back operations therefore take WIDTH+1 cycles each.
- If `start` is held high continuously, a new operation is accepted every WIDTH+1 cycles.
- `done` is never asserted without a preceding accepted `start`.
- Reset mid-RUN aborts the operation immediately:
  - no `done` is generated;
  - the outputs take their reset values;
  - the next `start` begins a fresh operation.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- WIDTH=8, `a`=0x35, `b`=0x12, `start` pulsed at edge k:
  - `done` high only in the cycle after edge k+8;
  - `diff`=0x23, `burrow`=0, `zero`=0;
  - `busy` high for exactly 8 cycles.
- WIDTH=8, `a`=0x12, `b`=0x35 → `diff`=0xDD, `burrow`=1, `zero`=0.
- WIDTH=8, `a`=0x00, `b`=0x01 → `diff`=0xFF, `burrow`=1. Then `a`=0x7C, `b`=0x7C → `diff`=0x00, `burrow`=0, `zero`=1.
- Busy and back-to-back handling:
  - Start 0x80−0x01, then pulse `start` with `a`=0xFF, `b`=0xFF at edge k+3: the request is ignored, and at completion `diff`=0x7F, `burrow`=0.
  - Then hold `start` high in the `done` cycle with `a`=0x05, `b`=0x07: the second `done` arrives 9 cycles after the first, with `diff`=0xFE, `burrow`=1.
- Reset mid-operation:
  - Assert `rst_n`=0 at cycle k+4 of a RUN: `busy`, `done`, `diff`, `burrow` go to 0 and `zero` to 1 without waiting for a clock edge.
  - No `done` appears afterwards.
  - A new 0x0A−0x03 then yields `diff`=0x07.
- WIDTH=2 and WIDTH=16, exhaustive (WIDTH=2) and 1000 random (WIDTH=16) operand pairs:
  - `{burrow, diff}` equals the reference `(a - b)` with borrow;
  - latency is always WIDTH cycles from the accepting edge to `done`.
